// File: rtl/alu_pkg.sv
// Shared constants and decoded-beat type for the ALU issue stage.
// Operand values live outside the struct so the datapath width stays a module parameter.
package alu_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef struct packed {
        logic [3:0] ctrl;
        logic [4:0] rd;
        logic       illegal;
    } dec_beat_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode into ALU operands and {alt_op, op} control.
// Every illegal encoding is forced to a=b=0, ctrl=ADD so execute sees a harmless beat.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [3:0]       ctrl,
    output logic [4:0]       rd,
    output logic             illegal
);

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0] imm_u;
    logic             f7_base;
    logic             f7_alt;

    assign opcode  = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign rd      = instr[11:7];
    assign imm_i   = WIDTH'($signed(instr[31:20]));
    assign imm_s   = WIDTH'($signed({instr[31:25], instr[11:7]}));
    assign imm_u   = WIDTH'($signed({instr[31:12], 12'b0}));
    assign f7_base = (f7 == 7'h00);
    assign f7_alt  = (f7 == 7'h20);

    always_comb begin
        a       = '0;
        b       = '0;
        ctrl    = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP: begin
                a       = rs1_data;
                b       = rs2_data;
                ctrl    = {f7[5], f3};
                illegal = !(f7_base || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_IMM: begin
                a = rs1_data;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // Shifts: shamt is unsigned, instr[30] selects SRA
                    b       = WIDTH'(instr[24:20]);
                    ctrl    = {instr[30], f3};
                    illegal = (f3 == 3'b001) ? !f7_base : !(f7_base || f7_alt);
                end else begin
                    b    = imm_i;
                    ctrl = {1'b0, f3};
                end
            end
            LUI:   b = imm_u;
            AUIPC: begin
                a = pc;
                b = imm_u;
            end
            LOAD: begin
                a = rs1_data;
                b = imm_i;
            end
            STORE: begin
                a = rs1_data;
                b = imm_s;
            end
            BRANCH: begin
                a = rs1_data;
                b = rs2_data;
                case (f3[2:1])
                    2'b00:   ctrl = ALU_SUB;
                    2'b10:   ctrl = ALU_SLT;
                    2'b11:   ctrl = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            JAL, JALR: begin
                a = pc;
                b = WIDTH'(32'd4);
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            a    = '0;
            b    = '0;
            ctrl = ALU_ADD;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode feeds a two-entry (OUT + SKID) valid/ready buffer.
// in_ready depends only on the skid flop, so there is no out_ready -> in_ready path.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [4:0]       out_rd,
    output logic             illegal
);

    logic [WIDTH-1:0] dec_a, dec_b;
    dec_beat_t        dec_beat;

    alu_ctrl_decode #(.WIDTH(WIDTH)) u_dec (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .a        (dec_a),
        .b        (dec_b),
        .ctrl     (dec_beat.ctrl),
        .rd       (dec_beat.rd),
        .illegal  (dec_beat.illegal)
    );

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    dec_beat_t        out_beat_q, out_beat_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    dec_beat_t        skid_beat_q, skid_beat_d;
    logic             accept, drain;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        skid_beat_d  = skid_beat_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            // accept cannot coincide with a valid skid, since in_ready is low then
            if (skid_valid_q) begin
                out_a_d      = skid_a_q;
                out_b_d      = skid_b_q;
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_a_d    = dec_a;
                out_b_d    = dec_b;
                out_beat_d = dec_beat;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_a_d     = dec_a;
                out_b_d     = dec_b;
                out_beat_d  = dec_beat;
            end else begin
                skid_valid_d = 1'b1;
                skid_a_d     = dec_a;
                skid_b_d     = dec_b;
                skid_beat_d  = dec_beat;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_beat_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            skid_beat_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_beat_q   <= out_beat_d;
            skid_valid_q <= skid_valid_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
            skid_beat_q  <= skid_beat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_a     = out_a_q;
    assign alu_b     = out_b_q;
    assign alu_ctrl  = out_beat_q.ctrl;
    assign out_rd    = out_beat_q.rd;
    assign illegal   = out_beat_q.illegal;

endmodule
